// File: rtl/led_arbiter.sv
// rtl/led_arbiter.sv - four-requester grant arbiter for the LED/switch datapath
//
// Purpose:
//   Treats sw[3:0] as request lines and grants one requester at a time for a
//   hold window of HOLD_CYCLES clocks. Ordering is round-robin or fixed
//   priority, where the lowest index wins. Every grant is followed by one dead
//   GAP cycle and then one IDLE evaluation cycle.
//
// Ports:
//   clk   - sole clock, rising edge
//   rst   - asynchronous active-high reset
//   btn   - btn[0] early release; btn[4:1] unused
//   sw    - sw[3:0] requests, sw[4] mode (1 = fixed), sw[7] enable; sw[6:5] unused
//   ledr  - [3:0] one-hot grant, [5:4] grant index, [6] grant valid,
//           [7] busy, [11:8] synchronized requests, [15:12] grant count mod 16

module led_arbiter #(
  parameter int unsigned HOLD_CYCLES = 32'd5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  btn,
  input  logic [7:0]  sw,
  output logic [15:0] ledr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // Loaded on grant start; the grant ends on the cycle this reaches zero.
  localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES - 1);

  // Synchronized bit layout: [6] enable, [5] mode, [4:1] requests, [0] release.
  logic [6:0]  r_sync1;
  logic [6:0]  r_sync2;
  logic        r_rel_q;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_owner;
  logic [1:0]  r_ptr;
  logic [31:0] r_hold_cnt;
  logic [3:0]  r_gcount;

  logic        w_en_s;
  logic        w_mode_s;
  logic [3:0]  w_req_s;
  logic        w_rel_s;
  logic        w_rel_edge;
  logic        w_start;
  logic        w_stop;
  logic [1:0]  w_base;
  logic [1:0]  w_winner;
  logic        w_found;

  logic [3:0]  w_grant_oh;
  logic [1:0]  w_grant_idx;
  logic        w_grant_vld;
  logic        w_busy;

  logic        w_unused;
  assign w_unused = &{1'b0, btn[4:1], sw[6:5]};

  // Input synchronizers and release edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_rel_q <= 1'b0;
    end else begin
      r_sync1 <= {sw[7], sw[4], sw[3:0], btn[0]};
      r_sync2 <= r_sync1;
      r_rel_q <= w_rel_s;
    end
  end

  assign w_en_s     = r_sync2[6];
  assign w_mode_s   = r_sync2[5];
  assign w_req_s    = r_sync2[4:1];
  assign w_rel_s    = r_sync2[0];
  assign w_rel_edge = w_rel_s & ~r_rel_q;

  assign w_start = w_en_s & (|w_req_s);
  assign w_stop  = (r_hold_cnt == 32'd0) | ~w_req_s[r_owner] | ~w_en_s | w_rel_edge;

  // Fixed priority is a scan that always starts at index 0; round-robin starts at ptr.
  assign w_base = w_mode_s ? 2'd0 : r_ptr;

  always_comb begin
    w_winner = 2'd0;
    w_found  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!w_found && w_req_s[w_base + 2'(k)]) begin
        w_winner = w_base + 2'(k);
        w_found  = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_GRANT;
      ST_GRANT: if (w_stop)  w_state_nxt = ST_GAP;
      ST_GAP:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner    <= 2'd0;
      r_ptr      <= 2'd0;
      r_hold_cnt <= 32'd0;
      r_gcount   <= 4'd0;
    end else if (r_state == ST_IDLE && w_start) begin
      r_owner    <= w_winner;
      r_ptr      <= w_winner + 2'd1;
      r_hold_cnt <= HOLD_LOAD;
      r_gcount   <= r_gcount + 4'd1;
    end else if (r_state == ST_GRANT && !w_stop) begin
      r_hold_cnt <= r_hold_cnt - 32'd1;
    end
  end

  // Output decode.
  always_comb begin
    w_grant_oh  = 4'b0000;
    w_grant_idx = 2'd0;
    w_grant_vld = 1'b0;
    w_busy      = (r_state != ST_IDLE);
    if (r_state == ST_GRANT) begin
      w_grant_oh  = 4'b0001 << r_owner;
      w_grant_idx = r_owner;
      w_grant_vld = 1'b1;
    end
  end

  assign ledr = {r_gcount, w_req_s, w_busy, w_grant_vld, w_grant_idx, w_grant_oh};

endmodule

// File: tb/tb_led_arbiter.sv
// tb/tb_led_arbiter.sv - self-checking bench for led_arbiter

module tb_led_arbiter;

  localparam int HOLD = 4;

  logic        clk;
  logic        rst;
  logic [4:0]  btn;
  logic [7:0]  sw;
  logic [15:0] ledr;

  int n_cmp;
  int n_bad;

  led_arbiter #(.HOLD_CYCLES(HOLD)) dut (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .sw   (sw),
    .ledr (ledr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a sampled-input pipeline and a grant described by
  // "granting with N cycles left", "in dead cycle", or neither.
  logic [7:0] m_s1, m_s2;
  logic       m_b1, m_b2, m_relq;
  bit         m_on, m_gap;
  int         m_left, m_owner, m_ptr, m_count;

  function void m_reset();
    m_s1 = 0; m_s2 = 0; m_b1 = 0; m_b2 = 0; m_relq = 0;
    m_on = 0; m_gap = 0; m_left = 0; m_owner = 0; m_ptr = 0; m_count = 0;
  endfunction

  function void m_step(input logic [7:0] s, input logic b);
    logic [3:0] req;
    bit en, fixed, rel;
    int w;
    req   = m_s2[3:0];
    en    = m_s2[7];
    fixed = m_s2[4];
    rel   = m_b2 && !m_relq;
    if (m_on) begin
      if (m_left == 1 || !req[m_owner] || !en || rel) begin
        m_on = 0;
        m_gap = 1;
      end else begin
        m_left = m_left - 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (en && req != 0) begin
      w = -1;
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = fixed ? k : (m_ptr + k) % 4;
        if (w < 0 && req[idx]) w = idx;
      end
      m_owner = w;
      m_ptr   = (w + 1) % 4;
      m_left  = HOLD;
      m_count = (m_count + 1) % 16;
      m_on    = 1;
    end
    m_relq = m_b2; m_b2 = m_b1; m_b1 = b;
    m_s2 = m_s1; m_s1 = s;
  endfunction

  function logic [15:0] m_ledr();
    logic [15:0] r;
    r = 16'h0000;
    r[15:12] = m_count[3:0];
    r[11:8]  = m_s2[3:0];
    if (m_on) begin
      r[m_owner] = 1'b1;
      r[5:4] = m_owner[1:0];
      r[6] = 1'b1;
      r[7] = 1'b1;
    end
    if (m_gap) r[7] = 1'b1;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Called just after a rising edge: asserts reset between edges, checks the
  // outputs clear without waiting for a clock, then releases after one edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check("async_reset_ledr", {16'h0, ledr}, 32'h0);
    m_reset();
    sw = 8'h00;
    btn = 5'h00;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic step(input logic [7:0] s, input logic [4:0] b, input string nm);
    sw = s;
    btn = b;
    @(posedge clk);
    m_step(s, b[0]);
    #1 check(nm, {16'h0, ledr}, {16'h0, m_ledr()});
  endtask

  typedef struct {
    logic [7:0]  sw;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[13];
  int   owners[$];
  int   starts[$];
  bit   prev;
  int   cnt;
  int   c;
  logic [7:0] rsw;
  logic [4:0] rbtn;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    sw = 8'h00;
    btn = 5'h00;
    m_reset();
    repeat (3) @(posedge clk);
    #1 check("reset_state", {16'h0, ledr}, 32'h0);
    rst = 1'b0;
    repeat (4) step(8'h00, 5'h00, "idle_no_req");

    // Single request on index 2: latency, hold length, gap, re-grant, drop.
    tbl[0]  = '{8'h84, 16'h0000};
    tbl[1]  = '{8'h84, 16'h0400};
    tbl[2]  = '{8'h84, 16'h14E4};
    tbl[3]  = '{8'h84, 16'h14E4};
    tbl[4]  = '{8'h84, 16'h14E4};
    tbl[5]  = '{8'h84, 16'h14E4};
    tbl[6]  = '{8'h84, 16'h1480};
    tbl[7]  = '{8'h84, 16'h1400};
    tbl[8]  = '{8'h84, 16'h24E4};
    tbl[9]  = '{8'h00, 16'h24E4};
    tbl[10] = '{8'h00, 16'h20E4};
    tbl[11] = '{8'h00, 16'h2080};
    tbl[12] = '{8'h00, 16'h2000};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      sw = tbl[i].sw;
      btn = 5'h00;
      @(posedge clk);
      m_step(tbl[i].sw, 1'b0);
      #1 check($sformatf("table_%0d", i), {16'h0, ledr}, {16'h0, tbl[i].exp});
    end

    // Reset in the middle of a grant.
    do_reset();
    c = 0;
    while (ledr[6] !== 1'b1 && c < 10) begin
      step(8'h81, 5'h00, "pre_reset_grant");
      c++;
    end
    check("pre_reset_grant_seen", {31'h0, ledr[6]}, 32'h1);
    do_reset();
    repeat (4) step(8'h00, 5'h00, "post_reset_idle");

    // Round-robin fairness with all four requesting.
    do_reset();
    owners.delete();
    starts.delete();
    prev = 0;
    for (int i = 0; i < 60 && owners.size() < 5; i++) begin
      step(8'h8F, 5'h00, "rr_model");
      if (ledr[6] && !prev) begin
        owners.push_back(int'(ledr[5:4]));
        starts.push_back(i);
      end
      prev = ledr[6];
    end
    check("rr_grant_count", owners.size(), 5);
    for (int i = 0; i < owners.size(); i++) begin
      check($sformatf("rr_order_%0d", i), owners[i], i % 4);
      if (i > 0) check($sformatf("rr_spacing_%0d", i), starts[i] - starts[i-1], HOLD + 2);
    end

    // Fixed priority: index 1 always beats index 3.
    do_reset();
    cnt = 0;
    prev = 0;
    for (int i = 0; i < 40; i++) begin
      step(8'h9A, 5'h00, "fixed_model");
      check("fixed_never_3", {31'h0, ledr[3]}, 32'h0);
      if (ledr[6] && !prev) begin
        check("fixed_index_1", {30'h0, ledr[5:4]}, 32'h1);
        cnt++;
      end
      prev = ledr[6];
    end
    check("fixed_grants_seen", (cnt >= 5) ? 32'h1 : 32'h0, 32'h1);

    // Early release held high: one drop, then a later grant is not blocked.
    do_reset();
    c = 0;
    while (ledr[6] !== 1'b1 && c < 10) begin
      step(8'h81, 5'h00, "rel_wait");
      c++;
    end
    check("rel_grant_seen", {31'h0, ledr[6]}, 32'h1);
    step(8'h81, 5'h01, "rel_e1");
    check("rel_e1_grant", {31'h0, ledr[6]}, 32'h1);
    step(8'h81, 5'h01, "rel_e2");
    check("rel_e2_grant", {31'h0, ledr[6]}, 32'h1);
    step(8'h81, 5'h01, "rel_e3");
    check("rel_e3_dropped", {31'h0, ledr[6]}, 32'h0);
    step(8'h81, 5'h01, "rel_idle");
    step(8'h81, 5'h01, "rel_regrant");
    check("rel_held_regrant", {31'h0, ledr[6]}, 32'h1);

    // Enable drop mid-grant: drop, then no grant while disabled.
    do_reset();
    c = 0;
    while (ledr[6] !== 1'b1 && c < 10) begin
      step(8'h81, 5'h00, "en_wait");
      c++;
    end
    check("en_grant_seen", {31'h0, ledr[6]}, 32'h1);
    step(8'h01, 5'h00, "en_e1");
    step(8'h01, 5'h00, "en_e2");
    check("en_e2_grant", {31'h0, ledr[6]}, 32'h1);
    step(8'h01, 5'h00, "en_e3");
    check("en_e3_dropped", {31'h0, ledr[6]}, 32'h0);
    for (int i = 0; i < 10; i++) begin
      step(8'h01, 5'h00, "en_low");
      check("en_low_no_grant", {31'h0, ledr[6]}, 32'h0);
    end

    // Grant counter wraps after 16.
    do_reset();
    cnt = 0;
    prev = 0;
    for (int i = 0; i < 200 && cnt < 17; i++) begin
      step(8'h81, 5'h00, "wrap_model");
      if (ledr[6] && !prev) cnt++;
      prev = ledr[6];
    end
    check("wrap_grants", cnt, 17);
    check("wrap_count", {28'h0, ledr[15:12]}, 32'h1);

    // Randomized traffic against the model.
    do_reset();
    rsw = 8'h80;
    rbtn = 5'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) begin
        rsw = 8'($urandom);
        rsw[7] = ($urandom_range(9) != 0);
      end
      rbtn = 5'($urandom);
      rbtn[0] = ($urandom_range(7) == 0) ? ~rbtn[0] : btn[0];
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        step(rsw, rbtn, "random");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
